// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming parallel-lane convolution block.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } conv_state_t;

  // Accumulator width that cannot overflow for f_size signed products.
  function automatic int acc_w(input int x_w, input int f_w, input int f_size);
    return x_w + f_w + $clog2(f_size);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/conv_load_ctrl.sv
// Per-stream load controller: write counter, full flag and ready for one memory.
module conv_load_ctrl
  import conv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic          i_clear,
  output logic          o_ready,
  output logic          o_we,
  output logic          o_full,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] r_cnt;
  logic          r_full;

  assign o_ready = i_en & ~r_full;
  assign o_we    = o_ready & i_valid;
  assign o_full  = r_full;
  assign o_addr  = r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (o_we) begin
      if (r_cnt == AW'(DEPTH - 1)) begin
        r_cnt  <= '0;
        r_full <= 1'b1;
      end else begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_stream_par.sv
// Streaming 1-D valid convolution: loads X and F into register memories, then
// computes each output over F_SIZE/LANES cycles and streams it out with a handshake.
module conv_stream_par
  import conv_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int F_W     = 8,
  parameter int X_SIZE  = 128,
  parameter int F_SIZE  = 32,
  parameter int LANES   = 4,
  parameter int OUT_W   = 21,
  parameter int RELU_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  input  logic [X_W-1:0]   s_data_x,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic [F_W-1:0]   s_data_f,
  input  logic             keep_f,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic [OUT_W-1:0] m_data_y,
  output logic             busy
);

  localparam int ACC_W = acc_w(X_W, F_W, F_SIZE);
  localparam int PW    = X_W + F_W;
  localparam int STEPS = F_SIZE / LANES;
  localparam int NOUT  = X_SIZE - F_SIZE + 1;
  localparam int XAW   = addr_w(X_SIZE);
  localparam int FAW   = addr_w(F_SIZE);
  localparam int SW    = addr_w(STEPS);
  localparam int NW    = addr_w(NOUT);
  localparam int EW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EW-1:0] OMAX = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  generate
    if (F_SIZE % LANES != 0) begin : g_bad_lanes
      $error("conv_stream_par: LANES must divide F_SIZE");
    end
    if (F_SIZE > X_SIZE) begin : g_bad_size
      $error("conv_stream_par: F_SIZE must not exceed X_SIZE");
    end
  endgenerate

  conv_state_t r_state, w_state_nxt;

  logic           w_in_load, w_we_x, w_we_f, w_full_x, w_full_f;
  logic           w_clr_x, w_clr_f, w_last_step, w_last_out;
  logic [XAW-1:0] w_waddr_x;
  logic [FAW-1:0] w_waddr_f;

  logic [X_W-1:0] r_xmem [X_SIZE];
  logic [F_W-1:0] r_fmem [F_SIZE];

  logic [NW-1:0]           r_n;
  logic [SW-1:0]           r_step;
  logic signed [ACC_W-1:0] r_acc, w_part, w_sum;
  logic signed [PW-1:0]    w_prod [LANES];
  logic signed [EW-1:0]    w_ext;
  logic [OUT_W-1:0]        w_sat, r_y;

  assign w_in_load = (r_state == ST_LOAD);

  conv_load_ctrl #(.DEPTH(X_SIZE), .AW(XAW)) u_load_x (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_in_load),
    .i_valid (s_valid_x),
    .i_clear (w_clr_x),
    .o_ready (s_ready_x),
    .o_we    (w_we_x),
    .o_full  (w_full_x),
    .o_addr  (w_waddr_x)
  );

  conv_load_ctrl #(.DEPTH(F_SIZE), .AW(FAW)) u_load_f (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_in_load),
    .i_valid (s_valid_f),
    .i_clear (w_clr_f),
    .o_ready (s_ready_f),
    .o_we    (w_we_f),
    .o_full  (w_full_f),
    .o_addr  (w_waddr_f)
  );

  always_ff @(posedge clk) begin
    if (w_we_x) r_xmem[w_waddr_x] <= s_data_x;
    if (w_we_f) r_fmem[w_waddr_f] <= s_data_f;
  end

  // Lane l of step s reads x[n + s*LANES + l] and f[s*LANES + l].
  always_comb begin
    w_part = '0;
    for (int unsigned lane = 0; lane < LANES; lane++) begin
      w_prod[lane] = $signed(r_xmem[XAW'(32'(r_n) + 32'(r_step) * LANES + lane)]) *
                     $signed(r_fmem[FAW'(32'(r_step) * LANES + lane)]);
      w_part = w_part + ACC_W'(w_prod[lane]);
    end
  end

  assign w_sum = (r_step == '0) ? w_part : r_acc + w_part;

  always_comb begin
    w_ext = EW'(w_sum);
    if (RELU_EN != 0 && w_ext[EW-1]) w_sat = '0;
    else if (w_ext > OMAX)           w_sat = OMAX[OUT_W-1:0];
    else if (w_ext < OMIN)           w_sat = OMIN[OUT_W-1:0];
    else                             w_sat = w_ext[OUT_W-1:0];
  end

  assign w_last_step = (r_step == SW'(STEPS - 1));
  assign w_last_out  = (r_n == NW'(NOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_x     = 1'b0;
    w_clr_f     = 1'b0;
    case (r_state)
      ST_LOAD:    if (w_full_x && w_full_f) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (w_last_step) w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: begin
        if (m_ready_y) begin
          if (w_last_out) begin
            w_state_nxt = ST_LOAD;
            w_clr_x     = 1'b1;
            w_clr_f     = ~keep_f;
          end else begin
            w_state_nxt = ST_COMPUTE;
          end
        end
      end
      default:    w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n    <= '0;
      r_step <= '0;
      r_acc  <= '0;
      r_y    <= '0;
    end else begin
      case (r_state)
        ST_COMPUTE: begin
          r_acc <= w_sum;
          if (w_last_step) begin
            r_step <= '0;
            r_y    <= w_sat;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        ST_OUTPUT: begin
          if (m_ready_y) r_n <= w_last_out ? '0 : r_n + NW'(1);
        end
        default: ;
      endcase
    end
  end

  assign m_valid_y = (r_state == ST_OUTPUT);
  assign m_data_y  = r_y;
  assign busy      = (r_state != ST_LOAD);

endmodule

// File: tb/tb_conv_stream_par.sv
// Scoreboard bench for conv_stream_par: small main instance plus saturating/ReLU pair.
`timescale 1ns/1ps
module tb_conv_stream_par;

  localparam int XS    = 8;
  localparam int FS    = 4;
  localparam int LN    = 2;
  localparam int NOUT  = XS - FS + 1;
  localparam int STEPS = FS / LN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_valid_x = 0, a_ready_x, a_valid_f = 0, a_ready_f, a_keep_f = 0;
  logic [7:0]  a_data_x = '0, a_data_f = '0;
  logic        a_m_valid, a_m_ready = 0, a_busy;
  logic [20:0] a_m_data;

  logic        bc_valid_x = 0, bc_valid_f = 0, bc_keep_f = 0, bc_m_ready = 0;
  logic [7:0]  bc_data_x = '0, bc_data_f = '0;
  logic        b_ready_x, b_ready_f, b_m_valid, b_busy;
  logic        c_ready_x, c_ready_f, c_m_valid, c_busy;
  logic [15:0] b_m_data, c_m_data;

  conv_stream_par #(.X_W(8), .F_W(8), .X_SIZE(XS), .F_SIZE(FS), .LANES(LN),
                    .OUT_W(21), .RELU_EN(0)) dut_a (
    .clk(clk), .reset(reset),
    .s_valid_x(a_valid_x), .s_ready_x(a_ready_x), .s_data_x(a_data_x),
    .s_valid_f(a_valid_f), .s_ready_f(a_ready_f), .s_data_f(a_data_f),
    .keep_f(a_keep_f),
    .m_valid_y(a_m_valid), .m_ready_y(a_m_ready), .m_data_y(a_m_data),
    .busy(a_busy)
  );

  conv_stream_par #(.X_W(8), .F_W(8), .X_SIZE(XS), .F_SIZE(FS), .LANES(LN),
                    .OUT_W(16), .RELU_EN(0)) dut_b (
    .clk(clk), .reset(reset),
    .s_valid_x(bc_valid_x), .s_ready_x(b_ready_x), .s_data_x(bc_data_x),
    .s_valid_f(bc_valid_f), .s_ready_f(b_ready_f), .s_data_f(bc_data_f),
    .keep_f(bc_keep_f),
    .m_valid_y(b_m_valid), .m_ready_y(bc_m_ready), .m_data_y(b_m_data),
    .busy(b_busy)
  );

  conv_stream_par #(.X_W(8), .F_W(8), .X_SIZE(XS), .F_SIZE(FS), .LANES(LN),
                    .OUT_W(16), .RELU_EN(1)) dut_c (
    .clk(clk), .reset(reset),
    .s_valid_x(bc_valid_x), .s_ready_x(c_ready_x), .s_data_x(bc_data_x),
    .s_valid_f(bc_valid_f), .s_ready_f(c_ready_f), .s_data_f(bc_data_f),
    .keep_f(bc_keep_f),
    .m_valid_y(c_m_valid), .m_ready_y(bc_m_ready), .m_data_y(c_m_data),
    .busy(c_busy)
  );

  int xv [XS];
  int fv [FS];
  int exp_q[$], obs_q[$], hold_q[$], hs_t[$];
  int exp_b[$], exp_c[$], obs_b[$], obs_c[$];
  int checks = 0;
  int errors = 0;

  function automatic int conv_ref(input int n);
    int s = 0;
    for (int k = 0; k < FS; k++) s += xv[n + k] * fv[k];
    return s;
  endfunction

  function automatic int sat_ref(input int v, input int ow, input bit relu);
    int mx = (1 << (ow - 1)) - 1;
    int mn = -(1 << (ow - 1));
    if (relu && v < 0) return 0;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic push_expected_a();
    for (int n = 0; n < NOUT; n++) exp_q.push_back(sat_ref(conv_ref(n), 21, 1'b0));
  endtask

  task automatic randomize_x();
    for (int i = 0; i < XS; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic drive_load_a(input bit send_f, input bit align, input bit xgap,
                              output int t_last, output bit f_ready_seen);
    int  ix, jf, k, fdel;
    bit  tx, tf;
    ix = 0; jf = send_f ? 0 : FS; k = 0; t_last = -1; f_ready_seen = 0;
    fdel = align ? XS - FS : 0;
    while ((ix < XS || jf < FS) && k < 200) begin
      a_valid_x = (ix < XS) && !(xgap && (k % 3 == 1));
      a_data_x  = 8'(xv[(ix < XS) ? ix : 0]);
      a_valid_f = send_f && (jf < FS) && (k >= fdel);
      a_data_f  = 8'(fv[(jf < FS) ? jf : 0]);
      if (a_ready_f) f_ready_seen = 1;
      tx = a_valid_x && a_ready_x;
      tf = a_valid_f && a_ready_f;
      if (tx || tf) t_last = cyc;
      if (tx) ix++;
      if (tf) jf++;
      @(negedge clk);
      k++;
    end
    a_valid_x = 0;
    a_valid_f = 0;
  endtask

  task automatic collect_a(input int n, input int stall_idx, input int stall_len,
                           output int t_first);
    int idx = 0, st = 0, k = 0;
    t_first = -1;
    while (idx < n && k < 200) begin
      a_m_ready = !(idx == stall_idx && st < stall_len);
      if (a_m_valid && t_first < 0) t_first = cyc;
      if (a_m_valid && !a_m_ready) begin
        hold_q.push_back(int'($signed(a_m_data)));
        st++;
      end
      if (a_m_valid && a_m_ready) begin
        obs_q.push_back(int'($signed(a_m_data)));
        hs_t.push_back(cyc);
        idx++;
      end
      @(negedge clk);
      k++;
    end
    a_m_ready = 0;
  endtask

  task automatic drive_load_bc();
    int ix = 0, jf = 0, k = 0;
    bit tx, tf;
    while ((ix < XS || jf < FS) && k < 200) begin
      bc_valid_x = ix < XS;
      bc_data_x  = 8'(xv[(ix < XS) ? ix : 0]);
      bc_valid_f = jf < FS;
      bc_data_f  = 8'(fv[(jf < FS) ? jf : 0]);
      tx = bc_valid_x && b_ready_x;
      tf = bc_valid_f && b_ready_f;
      if (tx) ix++;
      if (tf) jf++;
      @(negedge clk);
      k++;
    end
    bc_valid_x = 0;
    bc_valid_f = 0;
  endtask

  task automatic collect_bc(input int n);
    int k = 0;
    bc_m_ready = 1;
    while ((obs_b.size() < n || obs_c.size() < n) && k < 200) begin
      if (b_m_valid) obs_b.push_back(int'($signed(b_m_data)));
      if (c_m_valid) obs_c.push_back(int'($signed(c_m_data)));
      @(negedge clk);
      k++;
    end
    bc_m_ready = 0;
  endtask

  task automatic clear_obs();
    obs_q.delete(); hold_q.delete(); hs_t.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", a_m_valid); end
    checks++; if (a_m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0d expected 0", a_m_data); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_ready_x !== 1'b1) begin errors++; $display("FAIL reset_ready_x: got %b expected 1", a_ready_x); end
    checks++; if (a_ready_f !== 1'b1) begin errors++; $display("FAIL reset_ready_f: got %b expected 1", a_ready_f); end
    checks++; if (b_m_valid !== 1'b0 || c_m_valid !== 1'b0) begin errors++; $display("FAIL reset_bc_valid: got %b%b expected 00", b_m_valid, c_m_valid); end
  endtask

  task automatic test_basic();
    int t_last, t_first, e, o;
    bit frs;
    clear_obs();
    for (int i = 0; i < XS; i++) xv[i] = i + 1;
    for (int i = 0; i < FS; i++) fv[i] = 1;
    exp_q = '{10, 14, 18, 22, 26};
    drive_load_a(1'b1, 1'b0, 1'b0, t_last, frs);
    collect_a(NOUT, -1, 0, t_first);
    checks++; if (t_first - t_last !== STEPS + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", t_first - t_last, STEPS + 2); end
    checks++; if (obs_q.size() !== NOUT) begin errors++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), NOUT); end
    for (int i = 0; i < NOUT && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, o, e); end
    end
    for (int i = 1; i < hs_t.size(); i++) begin
      checks++; if (hs_t[i] - hs_t[i-1] !== STEPS + 1) begin errors++; $display("FAIL basic_interval[%0d]: got %0d expected %0d", i, hs_t[i] - hs_t[i-1], STEPS + 1); end
    end
    checks++; if (a_busy !== 1'b0 || a_m_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b valid=%b expected 0 0", a_busy, a_m_valid); end
    checks++; if (a_ready_x !== 1'b1 || a_ready_f !== 1'b1) begin errors++; $display("FAIL basic_empty: got rx=%b rf=%b expected 1 1", a_ready_x, a_ready_f); end
  endtask

  task automatic test_stall();
    int t_last, t_first, e, o;
    bit frs;
    clear_obs();
    for (int i = 0; i < XS; i++) xv[i] = i + 1;
    for (int i = 0; i < FS; i++) fv[i] = 1;
    push_expected_a();
    drive_load_a(1'b1, 1'b0, 1'b1, t_last, frs);
    collect_a(NOUT, 2, 5, t_first);
    checks++; if (hold_q.size() !== 5) begin errors++; $display("FAIL stall_hold_len: got %0d expected 5", hold_q.size()); end
    for (int i = 0; i < hold_q.size(); i++) begin
      checks++; if (hold_q[i] !== 18) begin errors++; $display("FAIL stall_hold[%0d]: got %0d expected 18", i, hold_q[i]); end
    end
    checks++; if (obs_q.size() !== NOUT) begin errors++; $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), NOUT); end
    for (int i = 0; i < NOUT && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, o, e); end
    end
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL stall_extra_valid: got %b expected 0", a_m_valid); end
  endtask

  task automatic test_keep_filter();
    int t_last, t_first, e, o;
    bit frs;
    clear_obs();
    randomize_x();
    fv = '{2, -3, 1, 5};
    push_expected_a();
    a_keep_f = 1;
    drive_load_a(1'b1, 1'b0, 1'b0, t_last, frs);
    collect_a(NOUT, -1, 0, t_first);
    a_keep_f = 0;
    checks++; if (obs_q.size() !== NOUT) begin errors++; $display("FAIL keep1_count: got %0d expected %0d", obs_q.size(), NOUT); end
    for (int i = 0; i < NOUT && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL keep1_data[%0d]: got %0d expected %0d", i, o, e); end
    end
    checks++; if (a_ready_f !== 1'b0) begin errors++; $display("FAIL keep_ready_f: got %b expected 0", a_ready_f); end
    clear_obs();
    randomize_x();
    push_expected_a();
    drive_load_a(1'b0, 1'b0, 1'b0, t_last, frs);
    checks++; if (frs !== 1'b0) begin errors++; $display("FAIL keep2_ready_f_seen: got %b expected 0", frs); end
    collect_a(NOUT, -1, 0, t_first);
    checks++; if (obs_q.size() !== NOUT) begin errors++; $display("FAIL keep2_count: got %0d expected %0d", obs_q.size(), NOUT); end
    for (int i = 0; i < NOUT && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL keep2_data[%0d]: got %0d expected %0d", i, o, e); end
    end
    checks++; if (a_ready_f !== 1'b1) begin errors++; $display("FAIL keep2_released: got %b expected 1", a_ready_f); end
  endtask

  task automatic test_same_cycle();
    int t_last, t_first, e, o;
    bit frs;
    clear_obs();
    randomize_x();
    for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
    push_expected_a();
    drive_load_a(1'b1, 1'b1, 1'b0, t_last, frs);
    collect_a(NOUT, -1, 0, t_first);
    checks++; if (t_first - t_last !== STEPS + 2) begin errors++; $display("FAIL same_latency: got %0d expected %0d", t_first - t_last, STEPS + 2); end
    checks++; if (obs_q.size() !== NOUT) begin errors++; $display("FAIL same_count: got %0d expected %0d", obs_q.size(), NOUT); end
    for (int i = 0; i < NOUT && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL same_data[%0d]: got %0d expected %0d", i, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int t_last, t_first, e, o;
    bit frs;
    clear_obs();
    randomize_x();
    for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
    push_expected_a();
    a_keep_f = 1;
    drive_load_a(1'b1, 1'b0, 1'b0, t_last, frs);
    collect_a(2, -1, 0, t_first);
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL mid_count: got %0d expected 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL mid_data[%0d]: got %0d expected %0d", i, o, e); end
    end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_in_compute: got busy=%b expected 1", a_busy); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    a_keep_f = 0;
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", a_m_valid); end
    checks++; if (a_ready_x !== 1'b1 || a_ready_f !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got rx=%b rf=%b expected 1 1", a_ready_x, a_ready_f); end
    clear_obs();
    randomize_x();
    for (int i = 0; i < FS; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
    push_expected_a();
    drive_load_a(1'b1, 1'b0, 1'b0, t_last, frs);
    collect_a(NOUT, -1, 0, t_first);
    checks++; if (obs_q.size() !== NOUT) begin errors++; $display("FAIL fresh_count: got %0d expected %0d", obs_q.size(), NOUT); end
    for (int i = 0; i < NOUT && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL fresh_data[%0d]: got %0d expected %0d", i, o, e); end
    end
  endtask

  task automatic test_saturate();
    int e, o;
    for (int pat = 0; pat < 2; pat++) begin
      obs_b.delete(); obs_c.delete(); exp_b.delete(); exp_c.delete();
      for (int i = 0; i < XS; i++) xv[i] = (pat == 0) ? 127 : -128;
      for (int i = 0; i < FS; i++) fv[i] = 127;
      for (int n = 0; n < NOUT; n++) begin
        exp_b.push_back((pat == 0) ? 32767 : -32768);
        exp_c.push_back((pat == 0) ? 32767 : 0);
      end
      drive_load_bc();
      collect_bc(NOUT);
      checks++; if (obs_b.size() !== NOUT || obs_c.size() !== NOUT) begin errors++; $display("FAIL sat%0d_count: got %0d/%0d expected %0d", pat, obs_b.size(), obs_c.size(), NOUT); end
      for (int i = 0; i < NOUT && obs_b.size() > 0; i++) begin
        e = exp_b.pop_front(); o = obs_b.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL sat%0d_b[%0d]: got %0d expected %0d", pat, i, o, e); end
      end
      for (int i = 0; i < NOUT && obs_c.size() > 0; i++) begin
        e = exp_c.pop_front(); o = obs_c.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL relu%0d_c[%0d]: got %0d expected %0d", pat, i, o, e); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_keep_filter();
    test_same_cycle();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
